// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the sequenced carry-lookahead adder:
//   - state_t : controller state encoding (IDLE / ADD / DONE)
//   - calc_nchunk    : number of CHUNK-bit slices in a WIDTH-bit operand
//   - calc_idx_width : width of the chunk index register (never below 1)
// ---------------------------------------------------------------------------
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int calc_idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// ---------------------------------------------------------------------------
// cla_chunk
// Combinational CHUNK-bit carry-lookahead adder slice.
// Ports:
//   a, b  in  CHUNK  operand slices
//   cin   in  1      carry into bit 0 of the slice
//   sum   out CHUNK  slice sum
//   cout  out 1      carry out of the top bit of the slice
// ---------------------------------------------------------------------------
module cla_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries are built inside one process so the chain reads as a single
  // combinational network rather than a vector feeding back on itself.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/cla_seq_controller.sv
// ---------------------------------------------------------------------------
// cla_seq_controller
// Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit CLA slice over
// WIDTH/CHUNK cycles, registering the carry between slices.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, cin           operands and carry-in, captured on acceptance
//   flush               synchronous abort back to IDLE, result discarded
//   busy                high while in ADD or DONE
//   out_valid,out_ready result handshake (out_valid high only in DONE)
//   sum, cout           registered result, stable while out_valid is high
// ---------------------------------------------------------------------------
module cla_seq_controller
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("cla_seq_controller: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  state_t           state_next;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             last_chunk;

  assign chunk_a    = a_q[idx*CHUNK +: CHUNK];
  assign chunk_b    = b_q[idx*CHUNK +: CHUNK];
  assign last_chunk = (idx == LAST_IDX);

  cla_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (chunk_a),
    .b   (chunk_b),
    .cin (carry),
    .sum (chunk_sum),
    .cout(chunk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // flush overrides every transition, including acceptance in IDLE.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // On flush the datapath simply freezes; sum/cout are meaningless until the
  // next completed addition raises out_valid again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            sum_q <= '0;
          end
        end
        ADD: begin
          sum_q[idx*CHUNK +: CHUNK] <= chunk_sum;
          carry                     <= chunk_cout;
          if (last_chunk) begin
            cout_q <= chunk_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
